program2: RTL and testbench
===========================

// Module: program2
// PURPOSE
// - Self-contained nibble-pattern match counter with its own 256x8 data memory.
// - Counts bytes in mem[32..95] that contain the 4-bit pattern mem[6][3:0] at any of 5 bit offsets.
// - Writes the count to mem[7] and raises done.
// - Top-level "program 2" engine; the bench preloads memory hierarchically and reads results back.
// PARAMETERS
// - MEM_DEPTH  256  data memory depth (8-bit words), internal array named data_ram
// - PAT_ADDR   6    address of pattern byte (only bits [3:0] used)
// - RES_ADDR   7    address receiving the match count
// - START_ADDR 32   first scanned byte
// - END_ADDR   95   last scanned byte (inclusive)
// - CYC_W      16   width of internal cycle counter cycle_ct
// PORTS
// - clk    in   1  single clock; all state updates on rising edge
// - rst_n  in   1  reset, synchronous, active-low
// - init   in   1  active-high hold/start: 1 = idle/loadable, 0 = run
// - done   out  1  high once the result is written; held until init=1 or reset
// BEHAVIOUR
// - Clocking: one clock, clk; reset is synchronous and active-low (rst_n).
// - Reset (rst_n=0 at edge): state=IDLE, done=0, cycle_ct=0, addr=START_ADDR, count=0.
//   - data_ram is NOT cleared.
//   - rst_n has priority over init.
// - IDLE: entered/held while init=1; done=0, cycle_ct=0, count=0, addr=START_ADDR.
//   - First edge with init=0 -> RUN.
// - RUN: one byte per clock, asynchronous memory read of data_ram[addr].
//   - match = any of b[3:0], b[4:1], b[5:2], b[6:3], b[7:4] == data_ram[PAT_ADDR][3:0].
//   - count += match; a byte counts once regardless of how many offsets match.
//   - addr++; after END_ADDR -> WRITE.
// - WRITE: one cycle; data_ram[RES_ADDR] <= count (8 bits, max 64) -> DONE.
// - DONE: done=1; cycle_ct frozen; memory static.
//   - init=1 -> IDLE on the next edge, done=0.
// - cycle_ct increments on every edge spent in RUN or WRITE: final value 65 (default params).
// - Latency: done rises 66 edges after the first edge with init=0.
// - init=1 mid-RUN/WRITE: abort to IDLE next edge; mem[RES_ADDR] unwritten if still in RUN.
// - Pattern byte upper nibble ignored. Pattern 0000 vs byte 0x00 counts once.
// - Memory is also written hierarchically by the bench while in IDLE; no port access.
// CONFIGURATION
// - Macro PROGRAM2_OCC_COUNT_EN.
// - Defined:
//   - also accumulate total occurrences (sum of matching offsets, 0..320).
//   - Extra state WR_OCC after WRITE writes min(total,255) to data_ram[8].
//   - cycle_ct final = 66.
// - Undefined: no occurrence logic, data_ram[8] never written, cycle_ct final = 65.
// TESTING
// - mem[6]=0x0D, mem[32..95]=0x00 -> mem[7]=0, done=1, cycle_ct=65.
// - mem[6]=0x0D, all bytes 0xDD -> mem[7]=64.
//   - With PROGRAM2_OCC_COUNT_EN: mem[8]=128, cycle_ct=66.
// - mem[6]=0xFD, mem[32]=0x1A, mem[33]=0xD0, rest 0x00 -> mem[7]=2 (offset [4:1], offset [7:4]; upper pattern bits ignored).
// - Preset mem[7]=0xAA, init=1 again 10 cycles after start:
//   - done stays 0, mem[7]=0xAA, cycle_ct=0.
//   - Rerun with init=0 -> correct count, cycle_ct=65.
// - rst_n=0 mid-RUN -> done=0, cycle_ct=0, mem[32..95] preserved; next run yields same count.
// - Back-to-back runs via init 1->0 with reloaded memory -> done drops in IDLE, second result correct.

Source files
------------

// File: rtl/program2.sv
// Nibble-pattern match counter: scans data_ram[START_ADDR..END_ADDR] for pattern data_ram[PAT_ADDR][3:0].
// Optional macro PROGRAM2_OCC_COUNT_EN adds a total-occurrence count written to data_ram[8].
module program2 #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned PAT_ADDR   = 6,
  parameter int unsigned RES_ADDR   = 7,
  parameter int unsigned START_ADDR = 32,
  parameter int unsigned END_ADDR   = 95,
  parameter int unsigned CYC_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  output logic done
);

  localparam int unsigned AW     = $clog2(MEM_DEPTH);
  localparam int unsigned DW     = 8;
  localparam int unsigned NOFF   = 5;
`ifdef PROGRAM2_OCC_COUNT_EN
  localparam int unsigned OCC_ADDR = 8;
  localparam int unsigned OCC_W    = 9;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_WR_OCC, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;
`endif

  logic [DW-1:0]    data_ram [MEM_DEPTH];
  logic [CYC_W-1:0] cycle_ct;

  state_t           r_state;
  state_t           r_next;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_count;
  logic             r_done;
`ifdef PROGRAM2_OCC_COUNT_EN
  logic [OCC_W-1:0] r_total;
  logic [2:0]       w_occ;
  logic [DW-1:0]    w_occ_sat;
`endif

  logic [DW-1:0]    w_byte;
  logic [3:0]       w_pat;
  logic [NOFF-1:0]  w_hits;
  logic             w_match;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [DW-1:0]    w_wdata;

  assign done = r_done;

  // Asynchronous read of the current byte and the pattern nibble
  assign w_byte = data_ram[r_addr];
  assign w_pat  = data_ram[PAT_ADDR][3:0];

  always_comb begin
    w_hits = '0;
    for (int k = 0; k < int'(NOFF); k++) begin
      w_hits[k] = (w_byte[k +: 4] == w_pat);
    end
  end

  assign w_match = |w_hits;

`ifdef PROGRAM2_OCC_COUNT_EN
  assign w_occ     = 3'($countones(w_hits));
  assign w_occ_sat = (r_total > OCC_W'(255)) ? 8'hFF : r_total[DW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= r_next;
    end
  end

  // init=1 forces IDLE from any state
  always_comb begin
    r_next = r_state;
    if (init) begin
      r_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_next = S_RUN;
        S_RUN:    if (r_addr == AW'(END_ADDR)) r_next = S_WRITE;
`ifdef PROGRAM2_OCC_COUNT_EN
        S_WRITE:  r_next = S_WR_OCC;
        S_WR_OCC: r_next = S_DONE;
`else
        S_WRITE:  r_next = S_DONE;
`endif
        S_DONE:   r_next = S_DONE;
        default:  r_next = S_IDLE;
      endcase
    end
  end

  // Result write port; suppressed on abort or reset
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (rst_n && !init) begin
      case (r_state)
        S_WRITE: begin
          w_we    = 1'b1;
          w_waddr = AW'(RES_ADDR);
          w_wdata = r_count;
        end
`ifdef PROGRAM2_OCC_COUNT_EN
        S_WR_OCC: begin
          w_we    = 1'b1;
          w_waddr = AW'(OCC_ADDR);
          w_wdata = w_occ_sat;
        end
`endif
        default: ;
      endcase
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      data_ram[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      cycle_ct <= '0;
      r_addr   <= AW'(START_ADDR);
      r_count  <= '0;
      r_done   <= 1'b0;
`ifdef PROGRAM2_OCC_COUNT_EN
      r_total  <= '0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          cycle_ct <= cycle_ct + CYC_W'(1);
          r_count  <= r_count + DW'(w_match);
          r_addr   <= r_addr + AW'(1);
`ifdef PROGRAM2_OCC_COUNT_EN
          r_total  <= r_total + OCC_W'(w_occ);
`endif
        end
`ifdef PROGRAM2_OCC_COUNT_EN
        S_WRITE: begin
          cycle_ct <= cycle_ct + CYC_W'(1);
        end
        S_WR_OCC: begin
          cycle_ct <= cycle_ct + CYC_W'(1);
          r_done   <= 1'b1;
        end
`else
        S_WRITE: begin
          cycle_ct <= cycle_ct + CYC_W'(1);
          r_done   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program2.sv
// Self-checking bench for program2: table of memory images plus abort, reset and random runs.
module tb_program2;

`ifdef PROGRAM2_OCC_COUNT_EN
  localparam int EXP_CYC = 66;
`else
  localparam int EXP_CYC = 65;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic init  = 1'b1;
  logic done;

  program2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] fill;
    logic [7:0] b32;
    logic [7:0] b33;
    int         cnt;
    int         occ;
  } vec_t;

  typedef struct {
    int cnt;
    int occ;
  } exp_t;

  exp_t       sb_q [$];
  vec_t       vecs [6];
  logic [7:0] img  [96];
  logic [7:0] cur_pat;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_image();
    dut.data_ram[6] = cur_pat;
    dut.data_ram[7] = 8'hAA;
    dut.data_ram[8] = 8'h5A;
    for (int i = 32; i <= 95; i++) dut.data_ram[i] = img[i];
  endtask

  task automatic load(input logic [7:0] pat, input logic [7:0] fill,
                      input logic [7:0] b32, input logic [7:0] b33);
    @(negedge clk);
    cur_pat = pat;
    for (int i = 32; i <= 95; i++) img[i] = fill;
    img[32] = b32;
    img[33] = b33;
    write_image();
  endtask

  task automatic load_random();
    @(negedge clk);
    cur_pat = 8'($urandom);
    for (int i = 32; i <= 95; i++) img[i] = 8'($urandom);
    write_image();
  endtask

  // Reference model: shift each byte and compare the low nibble
  function automatic exp_t model();
    exp_t e;
    e.cnt = 0;
    e.occ = 0;
    for (int i = 32; i <= 95; i++) begin
      int hits;
      hits = 0;
      for (int k = 0; k < 5; k++) begin
        if (((img[i] >> k) & 8'h0F) == {4'h0, cur_pat[3:0]}) hits++;
      end
      if (hits > 0) e.cnt++;
      e.occ += hits;
    end
    return e;
  endfunction

  task automatic run(input string tag);
    int   n;
    bit   got;
    exp_t e;
    int   occ_exp;
    @(negedge clk);
    init = 1'b0;
    n    = 0;
    got  = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    chk($sformatf("%s_done_seen", tag), int'(got), 1);
    if (got) chk($sformatf("%s_latency", tag), n, EXP_CYC + 1);
    if (sb_q.size() == 0) begin
      chk($sformatf("%s_sb_empty", tag), 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("%s_mem7", tag), int'(dut.data_ram[7]), e.cnt);
      chk($sformatf("%s_cycle_ct", tag), int'(dut.cycle_ct), EXP_CYC);
`ifdef PROGRAM2_OCC_COUNT_EN
      occ_exp = (e.occ > 255) ? 255 : e.occ;
`else
      occ_exp = 8'h5A;
`endif
      chk($sformatf("%s_mem8", tag), int'(dut.data_ram[8]), occ_exp);
    end
    @(posedge clk);
    #1;
    chk($sformatf("%s_done_held", tag), int'(done), 1);
    chk($sformatf("%s_cycle_frozen", tag), int'(dut.cycle_ct), EXP_CYC);
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("%s_done_drop", tag), int'(done), 0);
    chk($sformatf("%s_cycle_clr", tag), int'(dut.cycle_ct), 0);
  endtask

  initial begin
    int   bad;
    exp_t e;

    vecs[0] = '{8'h0D, 8'h00, 8'h00, 8'h00, 0, 0};
    vecs[1] = '{8'h0D, 8'hDD, 8'hDD, 8'hDD, 64, 128};
    vecs[2] = '{8'hFD, 8'h00, 8'h1A, 8'hD0, 2, 2};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 64, 320};
    vecs[4] = '{8'h05, 8'h55, 8'h55, 8'h55, 64, 192};
    vecs[5] = '{8'h0A, 8'h00, 8'hAA, 8'h5A, 2, 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", int'(done), 0);
    chk("reset_cycle_ct", int'(dut.cycle_ct), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table runs
    for (int v = 0; v < 6; v++) begin
      load(vecs[v].pat, vecs[v].fill, vecs[v].b32, vecs[v].b33);
      e.cnt = vecs[v].cnt;
      e.occ = vecs[v].occ;
      sb_q.push_back(e);
      run($sformatf("vec%0d", v));
    end

    // Abort mid-RUN leaves result unwritten
    load(8'h0D, 8'hDD, 8'hDD, 8'hDD);
    @(negedge clk);
    init = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_done", int'(done), 0);
    chk("abort_mem7", int'(dut.data_ram[7]), 8'hAA);
    chk("abort_cycle_ct", int'(dut.cycle_ct), 0);
    sb_q.push_back(model());
    run("abort_rerun");

    // Reset mid-RUN preserves memory
    load_random();
    @(negedge clk);
    init = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    init  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_cycle_ct", int'(dut.cycle_ct), 0);
    bad = 0;
    for (int i = 32; i <= 95; i++) if (dut.data_ram[i] !== img[i]) bad++;
    chk("rst_mem_preserved", bad, 0);
    chk("rst_mem7_unwritten", int'(dut.data_ram[7]), 8'hAA);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model());
    run("rst_rerun");

    for (int r = 0; r < 3; r++) begin
      load_random();
      sb_q.push_back(model());
      run($sformatf("rand%0d", r));
    end

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
